store_write_buffer: RTL

Posted-store buffer between the data cache and the RAM-bus arbiter of the RV32I core. Accepts word/half/byte stores in one cycle, holds up to DEPTH of them in program order, and drains them byte-serially onto the 8-bit RAM bus whenever the arbiter grants it. It also gives the data cache a combinational hazard check, so a load never reads memory a pending store has not yet written, and never reaches I/O space ahead of older stores.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_range_overlap.sv | 23 ++
 rtl/store_write_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the store write buffer.
//   - store size encodings and the size -> byte-count function
//   - default I/O region tag (addr[17:16])
//   - buffer entry layout {addr, data, nbytes}
package wb_pkg;

   localparam logic [1:0] CNF_BYTE = 2'd0;
   localparam logic [1:0] CNF_HALF = 2'd1;
   localparam logic [1:0] CNF_WORD = 2'd2;
   localparam logic [1:0] CNF_RSVD = 2'd3;  // drained as a word

   localparam logic [1:0] WB_IO_HI = 2'b11;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  nbytes;
   } wb_entry_t;

   function automatic logic [2:0] cnf_nbytes(input logic [1:0] cnf);
      case (cnf)
         CNF_BYTE: cnf_nbytes = 3'd1;
         CNF_HALF: cnf_nbytes = 3'd2;
         default:  cnf_nbytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/wb_range_overlap.sv
// wb_range_overlap: combinational byte-range intersect test.
//   a, na : first range  [a, a+na-1]
//   b, nb : second range [b, b+nb-1]
//   hit   : ranges share at least one byte
// Ranges are widened to 33 bits so an access near 0xFFFFFFFF does not
// wrap around and alias the bottom of the address space.
module wb_range_overlap (
   input  logic [31:0] a,
   input  logic [2:0]  na,
   input  logic [31:0] b,
   input  logic [2:0]  nb,
   output logic        hit
);

   logic [32:0] a_lo, a_hi, b_lo, b_hi;

   assign a_lo = {1'b0, a};
   assign b_lo = {1'b0, b};
   assign a_hi = a_lo + {30'b0, na} - 33'd1;
   assign b_hi = b_lo + {30'b0, nb} - 33'd1;
   assign hit  = (a_lo <= b_hi) && (b_lo <= a_hi);

endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: posted-store FIFO between data cache and RAM-bus
// arbiter. Stores are accepted in one cycle and drained byte-serially,
// in program order, onto the 8-bit bus whenever bus_grant is high.
//   push_*  : store from the data cache (push_ready = room available)
//   chk_*   : combinational load hazard query -> chk_conflict
//   bus_*   : byte write request/grant handshake to the arbiter
//   empty   : nothing held; count : entries held
module store_write_buffer
   import wb_pkg::*;
#(
   parameter int         DEPTH = 4,
   parameter logic [1:0] IO_HI = WB_IO_HI
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_valid,
   output logic                       push_ready,
   input  logic [31:0]                push_addr,
   input  logic [31:0]                push_data,
   input  logic [1:0]                 push_cnf,
   input  logic                       chk_valid,
   input  logic [31:0]                chk_addr,
   input  logic [1:0]                 chk_cnf,
   output logic                       chk_conflict,
   output logic                       bus_req,
   input  logic                       bus_grant,
   output logic                       bus_wr,
   output logic [31:0]                bus_addr,
   output logic [7:0]                 bus_dout,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic {S_IDLE, S_DRAIN} state_t;

   wb_entry_t      mem [DEPTH];
   wb_entry_t      hd;
   logic [PW-1:0]  head, tail;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [1:0]     byte_idx;
   state_t         state;
   logic           push_fire, last_byte, pop;
   logic [31:0]    byte_sh;
   logic [2:0]     chk_n;
   logic [DEPTH-1:0] ent_vld, ent_hit;

   assign hd         = mem[head];
   assign count      = cnt;
   assign empty      = (cnt == '0);
   // Full check uses the registered count only: a same-cycle pop does
   // not make room for a same-cycle push.
   assign push_ready = (cnt != CW'(DEPTH));
   assign push_fire  = push_valid && push_ready;

   assign bus_req    = (state == S_DRAIN);
   assign bus_wr     = bus_req && bus_grant;
   assign last_byte  = ({1'b0, byte_idx} == hd.nbytes - 3'd1);
   assign pop        = bus_wr && last_byte;
   assign cnt_nxt    = cnt + CW'(push_fire) - CW'(pop);

   assign byte_sh    = hd.data >> {byte_idx, 3'b000};
   assign bus_addr   = bus_req ? hd.addr + {30'b0, byte_idx} : 32'h0;
   assign bus_dout   = bus_req ? byte_sh[7:0] : 8'h00;

   // Entry storage carries no reset; validity comes from head/count.
   always_ff @(posedge clk) begin
      if (push_fire)
         mem[tail] <= '{addr: push_addr, data: push_data,
                        nbytes: cnf_nbytes(push_cnf)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         cnt      <= '0;
         byte_idx <= '0;
         state    <= S_IDLE;
      end else begin
         if (push_fire) tail <= tail + PW'(1);
         if (pop)       head <= head + PW'(1);
         cnt <= cnt_nxt;
         case (state)
            S_IDLE: if (cnt != '0) state <= S_DRAIN;
            S_DRAIN: begin
               if (bus_grant) begin
                  if (last_byte) begin
                     byte_idx <= '0;
                     // Next entry follows with no bubble unless drained out.
                     if (cnt_nxt == '0) state <= S_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Hazard check: the head stays valid until its final byte is granted,
   // so a partially written store still blocks overlapping loads.
   assign chk_n = cnf_nbytes(chk_cnf);

   for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
      logic [PW-1:0] off;
      assign off        = PW'(i) - head;
      assign ent_vld[i] = (CW'(off) < cnt);
      wb_range_overlap u_ovl (
         .a  (mem[i].addr),
         .na (mem[i].nbytes),
         .b  (chk_addr),
         .nb (chk_n),
         .hit(ent_hit[i])
      );
   end

   assign chk_conflict = chk_valid &&
                         ((|(ent_hit & ent_vld)) ||
                          ((chk_addr[17:16] == IO_HI) && !empty));

endmodule
